// File: rtl/fetch_align_pkg.sv
// ------------------------------------------------------------------
// fetch_align_pkg : shared fetch state encoding and RVC helpers (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

package fetch_align_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        PART = 2'd1,
        OUT  = 2'd2
    } fetch_state_t;

    // Low two bits of a 32-bit (non-compressed) instruction.
    localparam logic [1:0] QUAD_FULL = 2'b11;

    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != QUAD_FULL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_split.sv
// ------------------------------------------------------------------
// fetch_split : combinational instruction assembly from a memory beat (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module fetch_split
    import fetch_align_pkg::*;
(
    input  logic [31:0]  rdata,
    input  logic         pc_hi,
    input  logic [15:0]  hbuf,
    input  fetch_state_t state,
    output logic [31:0]  asm_instr,
    output logic         asm_compressed,
    output logic [15:0]  hbuf_new,
    output logic         hbuf_load,
    output fetch_state_t state_next
);

    logic [15:0] half;

    always_comb begin
        half           = pc_hi ? rdata[31:16] : rdata[15:0];
        asm_instr      = 32'h0;
        asm_compressed = 1'b0;
        hbuf_new       = rdata[31:16];
        hbuf_load      = 1'b0;
        state_next     = OUT;
        case (state)
            REQ: begin
                if (is_compressed(half)) begin
                    asm_instr      = {16'h0, half};
                    asm_compressed = 1'b1;
                    hbuf_load      = !pc_hi;
                end else if (!pc_hi) begin
                    asm_instr = rdata;
                end else begin
                    // 32-bit instruction starting in the upper half: park it
                    hbuf_new   = half;
                    hbuf_load  = 1'b1;
                    state_next = PART;
                end
            end
            PART: begin
                asm_instr = {rdata[15:0], hbuf};
                hbuf_load = 1'b1;
            end
            default: begin
                // OUT: candidate instruction served from the half buffer
                asm_instr      = {16'h0, hbuf};
                asm_compressed = is_compressed(hbuf);
                state_next     = is_compressed(hbuf) ? OUT : PART;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fetch_align.sv
// ------------------------------------------------------------------
// fetch_align : word fetch, RVC realignment and redirect handling (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module fetch_align
    import fetch_align_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state, state_d;
    logic [31:0]  fetch_pc, fetch_pc_d;
    logic [15:0]  hbuf, hbuf_d;
    logic [31:0]  hbuf_pc, hbuf_pc_d;
    logic         hbuf_full, hbuf_full_d;
    logic         drop, drop_d;
    logic         mem_valid_d, instr_valid_d;
    logic [31:0]  mem_addr_d, instr_d, pc_d;
    logic [31:0]  next_pc;

    logic [31:0]  split_instr;
    logic         split_compressed;
    logic [15:0]  split_hbuf;
    logic         split_load;
    fetch_state_t split_next;

    fetch_split u_split (
        .rdata          (mem_rdata),
        .pc_hi          (fetch_pc[1]),
        .hbuf           (hbuf),
        .state          (state),
        .asm_instr      (split_instr),
        .asm_compressed (split_compressed),
        .hbuf_new       (split_hbuf),
        .hbuf_load      (split_load),
        .state_next     (split_next)
    );

    assign next_pc = pc + (is_compressed(instr[15:0]) ? 32'd2 : 32'd4);

    always_comb begin
        state_d       = state;
        fetch_pc_d    = fetch_pc;
        hbuf_d        = hbuf;
        hbuf_pc_d     = hbuf_pc;
        hbuf_full_d   = hbuf_full;
        drop_d        = drop;
        mem_valid_d   = mem_valid;
        mem_addr_d    = mem_addr;
        instr_valid_d = instr_valid;
        instr_d       = instr;
        pc_d          = pc;

        if (redirect) begin
            state_d       = REQ;
            fetch_pc_d    = redirect_pc & ~32'd1;
            instr_valid_d = 1'b0;
            hbuf_full_d   = 1'b0;
            // An in-flight request must complete before the new one may issue
            if (mem_valid && !mem_ready) begin
                drop_d = 1'b1;
            end else begin
                drop_d      = 1'b0;
                mem_valid_d = 1'b1;
                mem_addr_d  = redirect_pc & ~32'd3;
            end
        end else if (mem_valid && mem_ready && drop) begin
            drop_d     = 1'b0;
            mem_addr_d = fetch_pc & ~32'd3;
        end else begin
            case (state)
                REQ, PART: begin
                    if (!mem_valid) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = fetch_pc & ~32'd3;
                    end else if (mem_ready) begin
                        state_d = split_next;
                        instr_d = split_instr;
                        pc_d    = (state == REQ) ? fetch_pc : hbuf_pc;
                        if (split_load) begin
                            hbuf_d      = split_hbuf;
                            hbuf_full_d = 1'b1;
                            hbuf_pc_d   = (state == REQ) ? ((fetch_pc & ~32'd3) | 32'd2)
                                                         : hbuf_pc + 32'd4;
                        end else begin
                            hbuf_full_d = 1'b0;
                        end
                        if (split_next == PART) begin
                            mem_addr_d = mem_addr + 32'd4;
                        end else begin
                            mem_valid_d   = 1'b0;
                            instr_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (instr_ready) begin
                        fetch_pc_d = next_pc;
                        if (hbuf_full && split_compressed) begin
                            instr_d     = split_instr;
                            pc_d        = hbuf_pc;
                            hbuf_full_d = 1'b0;
                            state_d     = split_next;
                        end else if (hbuf_full) begin
                            state_d       = split_next;
                            instr_valid_d = 1'b0;
                            mem_valid_d   = 1'b1;
                            mem_addr_d    = (hbuf_pc & ~32'd3) + 32'd4;
                        end else begin
                            state_d       = REQ;
                            instr_valid_d = 1'b0;
                            mem_valid_d   = 1'b1;
                            mem_addr_d    = next_pc & ~32'd3;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            hbuf        <= 16'h0;
            hbuf_pc     <= RESET_PC;
            hbuf_full   <= 1'b0;
            drop        <= 1'b0;
            mem_valid   <= 1'b0;
            mem_addr    <= RESET_PC & ~32'd3;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            pc          <= RESET_PC;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            hbuf        <= hbuf_d;
            hbuf_pc     <= hbuf_pc_d;
            hbuf_full   <= hbuf_full_d;
            drop        <= drop_d;
            mem_valid   <= mem_valid_d;
            mem_addr    <= mem_addr_d;
            instr_valid <= instr_valid_d;
            instr       <= instr_d;
            pc          <= pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_align.sv
// ------------------------------------------------------------------
// tb_fetch_align : directed vector bench for fetch_align (rev 1.0)
// ------------------------------------------------------------------
`default_nettype none

module tb_fetch_align;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] i0;
        logic [31:0] p0;
        logic [31:0] i1;
        logic [31:0] p1;
    } vec_t;

    vec_t vecs [7];

    assign mem_rdata = mem[mem_addr[9:2]];

    always #5 clk = ~clk;

    fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_valid"}, {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic [31:0] nxt;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;

        vecs[0] = '{32'h200, 32'h0050_0093, 32'h00A0_0113, 32'h0050_0093, 32'h200, 32'h00A0_0113, 32'h204};
        vecs[1] = '{32'h210, 32'h4501_4081, 32'h0000_0013, 32'h0000_4081, 32'h210, 32'h0000_4501, 32'h212};
        vecs[2] = '{32'h222, 32'h0093_4081, 32'h4081_0050, 32'h0050_0093, 32'h222, 32'h0000_4081, 32'h226};
        vecs[3] = '{32'h231, 32'h00A0_0113, 32'h4501_4081, 32'h00A0_0113, 32'h230, 32'h0000_4081, 32'h234};
        vecs[4] = '{32'h242, 32'h4505_0001, 32'h00A0_0113, 32'h0000_4505, 32'h242, 32'h00A0_0113, 32'h244};
        vecs[5] = '{32'h250, 32'h0093_0001, 32'h4081_0050, 32'h0000_0001, 32'h250, 32'h0050_0093, 32'h252};
        vecs[6] = '{32'hFFFF_FFFE, 32'h0093_0000, 32'h0000_0050, 32'h0050_0093, 32'hFFFF_FFFE, 32'h0000_0000, 32'h2};

        // Single 32-bit instruction after reset
        mem[0] = 32'h0050_0093;
        do_reset();
        check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        tick();
        check("t1_mem_valid", {31'h0, mem_valid}, 32'h1);
        check("t1_mem_addr", mem_addr, 32'h0);
        tick();
        check("t1_latency_valid", {31'h0, instr_valid}, 32'h1);
        check("t1_instr", instr, 32'h0050_0093);
        check("t1_pc", pc, 32'h0);
        accept();
        check("t1_next_addr", mem_addr, 32'h4);
        check("t1_next_mem_valid", {31'h0, mem_valid}, 32'h1);

        // Two compressed instructions in one word
        mem[0] = 32'h4501_4081;
        do_reset();
        wait_valid("t2a");
        check("t2_instr0", instr, 32'h0000_4081);
        check("t2_pc0", pc, 32'h0);
        accept();
        check("t2_b2b_valid", {31'h0, instr_valid}, 32'h1);
        check("t2_no_mem", {31'h0, mem_valid}, 32'h0);
        check("t2_instr1", instr, 32'h0000_4501);
        check("t2_pc1", pc, 32'h2);
        accept();
        check("t2_next_addr", mem_addr, 32'h4);

        // 32-bit instruction straddling a word boundary
        mem[0] = 32'h0093_4081;
        mem[1] = 32'h4081_0050;
        do_reset();
        wait_valid("t3a");
        check("t3_instr0", instr, 32'h0000_4081);
        check("t3_pc0", pc, 32'h0);
        accept();
        check("t3_part_addr", mem_addr, 32'h4);
        check("t3_part_invalid", {31'h0, instr_valid}, 32'h0);
        wait_valid("t3b");
        check("t3_instr1", instr, 32'h0050_0093);
        check("t3_pc1", pc, 32'h2);
        accept();
        check("t3_instr2", instr, 32'h0000_4081);
        check("t3_pc2", pc, 32'h6);

        // Redirect vectors issued from the OUT state
        mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            base = vecs[k].rpc & ~32'd3;
            nxt  = base + 32'd4;
            mem[base[9:2]] = vecs[k].w0;
            mem[nxt[9:2]]  = vecs[k].w1;
            redirect    = 1'b1;
            redirect_pc = vecs[k].rpc;
            tick();
            redirect = 1'b0;
            check($sformatf("v%0d_flush", k), {31'h0, instr_valid}, 32'h0);
            wait_valid($sformatf("v%0d_a", k));
            check($sformatf("v%0d_instr0", k), instr, vecs[k].i0);
            check($sformatf("v%0d_pc0", k), pc, vecs[k].p0);
            accept();
            wait_valid($sformatf("v%0d_b", k));
            check($sformatf("v%0d_instr1", k), instr, vecs[k].i1);
            check($sformatf("v%0d_pc1", k), pc, vecs[k].p1);
        end

        // Redirect while a request is stalled
        mem[0]  = 32'h0050_0093;
        mem[64] = 32'h4505_0001;
        mem_ready = 1'b0;
        do_reset();
        tick();
        check("t4_req_addr", mem_addr, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        for (int c = 0; c < 3; c++) begin
            tick();
            redirect = 1'b0;
            check("t4_hold_addr", mem_addr, 32'h0);
            check("t4_hold_valid", {31'h0, mem_valid}, 32'h1);
        end
        mem_ready = 1'b1;
        tick();
        check("t4_drop_invalid", {31'h0, instr_valid}, 32'h0);
        check("t4_new_addr", mem_addr, 32'h100);
        wait_valid("t4");
        check("t4_instr", instr, 32'h0000_4505);
        check("t4_pc", pc, 32'h102);

        // Decoder stall keeps the instruction steady
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t5_valid", {31'h0, instr_valid}, 32'h1);
            check("t5_instr", instr, 32'h0000_4505);
            check("t5_pc", pc, 32'h102);
            check("t5_no_mem", {31'h0, mem_valid}, 32'h0);
        end
        accept();
        check("t5_next_addr", mem_addr, 32'h104);

        // Reset while a straddling instruction is half assembled
        mem[0] = 32'h0093_4081;
        mem[1] = 32'h4081_0050;
        do_reset();
        wait_valid("t6a");
        mem_ready = 1'b0;
        accept();
        check("t6_part_valid", {31'h0, mem_valid}, 32'h1);
        check("t6_part_addr", mem_addr, 32'h4);
        reset = 1'b1;
        tick();
        check("t6_rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        check("t6_rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_addr", mem_addr, 32'h0);
        reset = 1'b0;
        mem_ready = 1'b1;
        wait_valid("t6b");
        check("t6_instr", instr, 32'h0000_4081);
        check("t6_pc", pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Instruction fetch and realignment stage directly upstream of the instruction decoder.
- Issues word-aligned reads to instruction memory and splits each word into 16-bit (RVC) or 32-bit instructions.
- Handles 32-bit instructions that straddle a word boundary.
- Presents one instruction plus its pc per valid/ready handshake to the decode stage, and accepts pc redirects from execute (jumps/branches).

Parameters:
RESET_PC  32'h0000_0000  pc of first instruction fetched after reset; must be halfword aligned

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
mem_valid  output  1  read request asserted
mem_addr  output  32  word-aligned read address, bits [1:0] always 0
mem_ready  input  1  request accepted; mem_rdata valid this cycle
mem_rdata  input  32  read data
instr_valid  output  1  instr/pc hold a complete instruction
instr_ready  input  1  decoder accepts the instruction this cycle
instr  output  32  instruction; compressed instructions zero-extended in [31:16]
pc  output  32  address of instr
redirect  input  1  discard all state and restart fetch at redirect_pc
redirect_pc  input  32  new fetch pc; bit 0 ignored (treated 0)

Behaviour:
- One clock, synchronous active-high reset. All outputs registered.
- Reset values:
  - mem_valid=0, mem_addr=RESET_PC&~3, instr_valid=0, instr=0, pc=RESET_PC.
  - Internal: fetch_pc=RESET_PC, half buffer empty, state=REQ.
- mem_valid rises the first cycle after reset deasserts.
- Memory handshake:
  - Transfer occurs when mem_valid && mem_ready.
  - Once raised, mem_valid and mem_addr stay stable until mem_ready.
  - One outstanding request at most.
- Internal state: fetch_pc, plus a half buffer {hbuf[15:0], hbuf_pc, hbuf_full}.
- FSM states:
  - REQ: request outstanding for word fetch_pc&~3.
  - PART: request outstanding for the next word; the lower half of a straddling 32-bit instruction is held in hbuf.
  - OUT: instr_valid=1, waiting for instr_ready.
- Assembly on a REQ beat, with h = fetch_pc[1] ? rdata[31:16] : rdata[15:0]:
  - If h[1:0]!=2'b11 (compressed): emit {16'b0,h}, pc=fetch_pc. If fetch_pc[1]==0, store rdata[31:16] in hbuf with hbuf_pc=fetch_pc+2. Go to OUT.
  - Else, if fetch_pc[1]==0: emit rdata, pc=fetch_pc. Go to OUT.
  - Else (upper-half 32-bit start): hbuf=h, hbuf_pc=fetch_pc. Go to PART.
- PART beat: emit {rdata[15:0],hbuf}, pc=hbuf_pc. Store rdata[31:16] in hbuf with hbuf_pc=hbuf_pc+4. Go to OUT.
- OUT && instr_ready: fetch_pc=pc+(compressed?2:4). Then:
  - If hbuf_full and hbuf is compressed: emit {16'b0,hbuf} next cycle, no memory access; stay OUT, buffer cleared.
  - If hbuf_full and hbuf starts a 32-bit instruction: request the next word and go to PART.
  - Else: go to REQ.
- Back-to-back: instr_valid may stay high across consecutive accepts when the next instruction is served from hbuf.
- Throughput: the memory request is issued the cycle after accept.
- Latency: a REQ with mem_ready in the same cycle asserts instr_valid the next cycle.
- Redirect (highest priority):
  - Next cycle: instr_valid=0, hbuf_full=0, fetch_pc=redirect_pc&~1.
  - No request outstanding: mem_valid/mem_addr for the new word next cycle, state REQ.
  - Request outstanding without mem_ready: mem_valid/mem_addr held; the returning beat is discarded; the new request issues the cycle after that beat.
  - mem_ready in the same cycle as redirect: beat discarded, new request next cycle.
  - A second redirect before restart overwrites the target.
  - Redirect while instr_valid && instr_ready in the same cycle: the instruction counts as accepted, then the redirect applies.
- Reset mid-operation: immediate return to reset values; a pending memory transfer is abandoned; memory must tolerate the dropped request.
- Address arithmetic is modulo 2^32; fetch_pc wraps from 32'hFFFF_FFFE to 0.

Decomposition:
- Shared package holds:
  - fetch state enum {REQ, PART, OUT};
  - QUAD_FULL=2'b11;
  - function is_compressed(logic[15:0]).
- The decoder reuses QUAD_FULL.
- One combinational sub-module, fetch_split: inputs rdata, fetch_pc[1], hbuf, state; outputs assembled instr, compressed flag, new hbuf, next state.
- FSM and handshakes stay in fetch_align.

Test Plan:
1. Reset, RESET_PC=0, mem word0=32'h00500093 (addi), mem_ready always 1 -> mem_addr=0, instr=32'h00500093 pc=0, next mem_addr=4.
2. Word0=32'h4501_4081 (two RVC) -> instr=32'h4081 pc=0, then instr=32'h4501 pc=2 with no mem_valid between; then mem_addr=4.
3. Straddle: word0={32-bit lower 16'h0093,RVC 16'h4081}, word1={16'h4081,16'h0050} -> instr=32'h4081 pc=0, then instr=32'h00500093 pc=2 after one fetch of addr 4, then instr=32'h4081 pc=6 from hbuf.
4. redirect_pc=32'h102 while mem_ready held 0 for 3 cycles -> mem_addr stays old until ready, beat dropped, next request mem_addr=32'h100, first instr pc=32'h102 from upper half.
5. instr_ready held 0 for 5 cycles with valid instr -> instr/pc stable, mem_valid=0 throughout, no drop.
6. Assert reset during PART with hbuf_full -> next cycle instr_valid=0, mem_valid=0, pc=RESET_PC; first instr after release from RESET_PC.
